// File: rtl/rd_handshake_tx.sv
// rd_handshake_tx: source end of a two-phase (toggle) req/ack CDC link.
// SYNC_STAGES must be at least 3; the far end must come out of reset with ack low.
module rd_handshake_tx #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_in_i,
   input  logic                  data_valid_i,
   output logic                  data_ready_o,
   output logic [DATA_WIDTH-1:0] data_out_o,
   output logic                  req_out_o,
   input  logic                  ack_in_i,
   output logic                  xfer_done_o,
   output logic [CNT_WIDTH-1:0]  xfer_count_o,
   output logic                  timeout_err_o,
   input  logic                  err_clr_i
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t                state_q, state_d;
   logic                  req_q, req_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic [CNT_WIDTH-1:0]  xferCount_q, xferCount_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  timeoutErr_q, timeoutErr_d;
   logic                  errSet;
   logic                  ackSync;

   (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
   logic [SYNC_STAGES-1:0] sync_q;

   assign ackSync = sync_q[SYNC_STAGES-1];

   // A transfer completes when the synchronized ack catches up with our request toggle;
   // the timeout only flags a lost ack, it never abandons the outstanding toggle.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      data_d      = data_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      xferCount_d = xferCount_q;
      timer_d     = timer_q;
      errSet      = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (data_valid_i && ready_q) begin
               data_d  = data_in_i;
               req_d   = ~req_q;
               ready_d = 1'b0;
               timer_d = '0;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ackSync == req_q) begin
               done_d      = 1'b1;
               xferCount_d = xferCount_q + CNT_WIDTH'(1);
               ready_d     = 1'b1;
               state_d     = IDLE;
            end else if (timer_q != TMAX) begin
               timer_d = timer_q + TW'(1);
               errSet  = (TIMEOUT != 0) && (timer_d == TMAX);
            end
         end
         default: state_d = IDLE;
      endcase
      timeoutErr_d = errSet | (timeoutErr_q & ~err_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         data_q       <= '0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         xferCount_q  <= '0;
         timer_q      <= '0;
         timeoutErr_q <= 1'b0;
         sync_q       <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         data_q       <= data_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         xferCount_q  <= xferCount_d;
         timer_q      <= timer_d;
         timeoutErr_q <= timeoutErr_d;
         sync_q       <= {sync_q[SYNC_STAGES-2:0], ack_in_i};
      end
   end

   assign data_ready_o  = ready_q;
   assign data_out_o    = data_q;
   assign req_out_o     = req_q;
   assign xfer_done_o   = done_q;
   assign xfer_count_o  = xferCount_q;
   assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_rd_handshake_tx.sv
// tb_rd_handshake_tx: random and directed traffic against a transaction-level model
// of the toggle handshake, with a far-end responder and an in-order word scoreboard.
module tb_rd_handshake_tx;

   localparam int DW      = 32;
   localparam int SS      = 3;
   localparam int TO      = 16;
   localparam int CW      = 4;
   localparam int CNT_MOD = 1 << CW;

   logic          clock = 1'b0;
   logic          rst;
   logic [DW-1:0] dataIn;
   logic          dataValid;
   logic          dataReady;
   logic [DW-1:0] dataOut;
   logic          reqOut;
   logic          ackIn;
   logic          xferDone;
   logic [CW-1:0] xferCount;
   logic          timeoutErr;
   logic          errClr;

   int total = 0;
   int bad   = 0;

   bit            mBusy, mReq, mReady, mDone, mErr, mAccept;
   logic [DW-1:0] mData;
   int            mCount, mTimer;
   bit            ackHist[$];
   logic [DW-1:0] txQ[$];
   logic [DW-1:0] rxQ[$];

   bit farEn, farReq;
   int farWait, farLo, farHi;
   int doneSeen;

   always #5 clock = ~clock;

   rd_handshake_tx #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SS),
      .TIMEOUT    (TO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk_i        (clock),
      .rst_i        (rst),
      .data_in_i    (dataIn),
      .data_valid_i (dataValid),
      .data_ready_o (dataReady),
      .data_out_o   (dataOut),
      .req_out_o    (reqOut),
      .ack_in_i     (ackIn),
      .xfer_done_o  (xferDone),
      .xfer_count_o (xferCount),
      .timeout_err_o(timeoutErr),
      .err_clr_i    (errClr)
   );

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model advanced once per clock edge, from the inputs held across that edge.
   // The ack seen by the source is the ACK_IN level sampled SS edges earlier.
   task automatic modelStep();
      bit ackS;
      bit setErr;
      mAccept = 1'b0;
      setErr  = 1'b0;
      if (rst) begin
         mBusy  = 1'b0;
         mReq   = 1'b0;
         mReady = 1'b0;
         mDone  = 1'b0;
         mData  = '0;
         mCount = 0;
         mTimer = 0;
         mErr   = 1'b0;
         ackHist.delete();
         for (int i = 0; i < SS; i++) ackHist.push_back(1'b0);
         return;
      end
      ackS = ackHist[SS-1];
      ackHist.push_front(ackIn);
      void'(ackHist.pop_back());
      mDone = 1'b0;
      if (mBusy) begin
         if (ackS == mReq) begin
            mBusy  = 1'b0;
            mDone  = 1'b1;
            mCount = (mCount + 1) % CNT_MOD;
            mReady = 1'b1;
         end else if (mTimer < TO) begin
            mTimer++;
            if (mTimer == TO) setErr = 1'b1;
         end
      end else if (dataValid && mReady) begin
         mData   = dataIn;
         mReq    = !mReq;
         mReady  = 1'b0;
         mTimer  = 0;
         mBusy   = 1'b1;
         mAccept = 1'b1;
         txQ.push_back(dataIn);
      end else begin
         mReady = 1'b1;
      end
      if (setErr) mErr = 1'b1;
      else if (errClr) mErr = 1'b0;
   endtask

   // One clock: advance the model, check all outputs #1 after the edge, then let the
   // far end capture new words and (if enabled) return the ack after a random delay.
   task automatic stepCycle();
      @(posedge clock);
      modelStep();
      #1;
      checkOutput("ready", dataReady, mReady);
      checkOutput("req", reqOut, mReq);
      checkOutput("data", dataOut, mData);
      checkOutput("done", xferDone, mDone);
      checkOutput("count", xferCount, mCount);
      checkOutput("err", timeoutErr, mErr);
      if (xferDone === 1'b1) doneSeen++;
      if (rst) begin
         farReq  = 1'b0;
         farWait = 0;
      end else begin
         if (reqOut !== farReq) begin
            farReq  = reqOut;
            rxQ.push_back(dataOut);
            farWait = $urandom_range(farHi, farLo);
         end
         if (farEn && farWait > 0) begin
            farWait--;
            if (farWait == 0) ackIn = farReq;
         end
      end
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while ((mBusy || !mReady) && n < limit) begin
         stepCycle();
         n++;
      end
      checkOutput("idleReady", dataReady, 1'b1);
   endtask

   task automatic applyStimulus();
      int            n;
      int            idx;
      int            cnt;
      int            rxBase;
      logic [DW-1:0] w[4];

      // reset: everything low while held, ready one edge after release
      repeat (3) begin
         stepCycle();
         checkOutput("rstReady", dataReady, 1'b0);
         checkOutput("rstReq", reqOut, 1'b0);
      end
      rst = 1'b0;
      stepCycle();
      checkOutput("readyAfterRst", dataReady, 1'b1);

      // single word, ack returned by hand five cycles later
      dataIn    = 32'hDEADBEEF;
      dataValid = 1'b1;
      stepCycle();
      dataValid = 1'b0;
      dataIn    = $urandom;
      checkOutput("t2Req", reqOut, 1'b1);
      checkOutput("t2Data", dataOut, 32'hDEADBEEF);
      repeat (5) stepCycle();
      checkOutput("t2Held", dataOut, 32'hDEADBEEF);
      ackIn    = 1'b1;
      doneSeen = 0;
      n        = 0;
      while (xferDone !== 1'b1 && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput("t2DoneLat", n, SS + 1);
      repeat (4) stepCycle();
      checkOutput("t2DoneOnce", doneSeen, 1);
      checkOutput("t2Count", xferCount, 1);

      // four words back to back with valid held high
      farEn  = 1'b1;
      farLo  = 1;
      farHi  = 4;
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      rxBase    = rxQ.size();
      idx       = 0;
      n         = 0;
      dataValid = 1'b1;
      dataIn    = w[0];
      while (idx < 4 && n < 200) begin
         stepCycle();
         n++;
         if (mAccept) begin
            idx++;
            if (idx < 4) dataIn = w[idx];
         end
      end
      dataValid = 1'b0;
      waitIdle(200);
      checkOutput("t3Count", xferCount, 5);
      checkOutput("t3RxN", rxQ.size() - rxBase, 4);
      for (int i = 0; i < 4 && rxBase + i < rxQ.size(); i++)
         checkOutput("t3Word", rxQ[rxBase+i], w[i]);

      // lost ack: timeout flags after TO waiting cycles, late ack still completes
      farEn     = 1'b0;
      farWait   = 0;
      dataIn    = $urandom;
      dataValid = 1'b1;
      stepCycle();
      dataValid = 1'b0;
      repeat (TO - 1) stepCycle();
      checkOutput("t4ErrEarly", timeoutErr, 1'b0);
      stepCycle();
      checkOutput("t4ErrSet", timeoutErr, 1'b1);
      checkOutput("t4Ready", dataReady, 1'b0);
      repeat (5) stepCycle();
      ackIn    = mReq;
      doneSeen = 0;
      n        = 0;
      while (xferDone !== 1'b1 && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput("t4Done", doneSeen, 1);
      stepCycle();
      checkOutput("t4ErrSticky", timeoutErr, 1'b1);
      checkOutput("t4ReadyBack", dataReady, 1'b1);
      errClr = 1'b1;
      stepCycle();
      errClr = 1'b0;
      checkOutput("t4ErrClr", timeoutErr, 1'b0);

      // reset while waiting, then a spurious ack toggle in idle
      dataIn    = $urandom;
      dataValid = 1'b1;
      stepCycle();
      dataValid = 1'b0;
      repeat (3) stepCycle();
      rst   = 1'b1;
      ackIn = 1'b0;
      stepCycle();
      checkOutput("t6Req", reqOut, 1'b0);
      checkOutput("t6Data", dataOut, 0);
      checkOutput("t6CountRst", xferCount, 0);
      stepCycle();
      rst = 1'b0;
      stepCycle();
      ackIn    = 1'b1;
      doneSeen = 0;
      repeat (8) stepCycle();
      checkOutput("t6NoDone", doneSeen, 0);
      checkOutput("t6CountHold", xferCount, 0);
      checkOutput("t6Ready", dataReady, 1'b1);
      ackIn = 1'b0;
      repeat (5) stepCycle();

      // seventeen transfers from zero wrap the 4-bit count to 1
      farEn = 1'b1;
      farLo = 1;
      farHi = 5;
      cnt   = 0;
      n     = 0;
      while (cnt < 17 && n < 2000) begin
         dataValid = ($urandom_range(9, 0) < 7);
         dataIn    = $urandom;
         stepCycle();
         n++;
         if (mAccept) cnt++;
      end
      dataValid = 1'b0;
      waitIdle(200);
      checkOutput("t5Wrap", xferCount, 1);

      // random soak with slow acks (timeouts) and occasional error clears
      farHi = 24;
      repeat (400) begin
         dataValid = $urandom_range(1, 0);
         dataIn    = $urandom;
         errClr    = ($urandom_range(15, 0) == 0);
         stepCycle();
      end
      dataValid = 1'b0;
      errClr    = 1'b0;
      waitIdle(500);
   endtask

   initial begin
      rst       = 1'b1;
      dataIn    = '0;
      dataValid = 1'b0;
      ackIn     = 1'b0;
      errClr    = 1'b0;
      farEn     = 1'b0;
      farReq    = 1'b0;
      farWait   = 0;
      farLo     = 1;
      farHi     = 6;
      doneSeen  = 0;
      applyStimulus();
      checkOutput("sbSize", rxQ.size(), txQ.size());
      for (int i = 0; i < rxQ.size() && i < txQ.size(); i++)
         checkOutput("sbWord", rxQ[i], txQ[i]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
